therm_n1_load_store_unit: RTL
=============================

// Module: therm_n1_load_store_unit
// PURPOSE
//  Parametrised load/store unit for the ThermN1 core. It takes one load or store request from decode and issues a
//  single aligned, byte-enabled access on the simple memory bus, waiting as long as the memory needs. For loads it
//  selects the addressed byte lanes, then sign- or zero-extends them (funct3 encoding) and returns the result with
//  its rd index. Misaligned or illegal-size accesses are rejected with an error and never reach memory.
// PARAMETERS
//  XLEN            64  data path width; 32 or 64 only
//  ADDR_WIDTH      64  byte address width
//  RD_WIDTH        5   destination register index width
//  ALLOW_MISALIGN  0   reserved; must be 0 (misaligned access always reports an error)
// PORTS
//  clock            in   1           rising-edge clock
//  reset            in   1           synchronous, active-high reset
//  req_valid        in   1           request present
//  req_ready        out  1           unit can accept a request
//  req_is_store     in   1           1 = store, 0 = load
//  req_funct3       in   3           [1:0] size (00 B, 01 H, 10 W, 11 D); [2] 1 = zero-extend (loads only)
//  req_base         in   ADDR_WIDTH  rs1 value
//  req_offset       in   ADDR_WIDTH  sign-extended immediate
//  req_store_data   in   XLEN        rs2 value; low 2^size bytes are stored
//  req_rd           in   RD_WIDTH    load destination index
//  mem_address      out  ADDR_WIDTH  access address, aligned to XLEN/8 bytes
//  mem_chip_enable  out  1           access in progress
//  mem_write_enable out  1           1 = write
//  mem_byte_enable  out  XLEN/8      active byte lanes
//  mem_data_store   out  XLEN        write data, shifted to the active lanes
//  mem_data_load    in   XLEN        read data; valid in the cycle mem_ready is high
//  mem_ready        in   1           access completes this cycle
//  resp_valid       out  1           response present
//  resp_ready       in   1           consumer accepts the response
//  resp_rd          out  RD_WIDTH    echo of req_rd (0 for stores)
//  resp_data        out  XLEN        extended load data (0 for stores or on error)
//  resp_error       out  1           misaligned address or illegal size
// BEHAVIOUR
//  - FSM states: IDLE, ACCESS, RESPOND. Reset forces IDLE and clears every output to 0, including req_ready.
//    req_ready is 1 only while in IDLE.
//  - IDLE: on req_valid && req_ready, compute ea = req_base + req_offset (wraps mod 2^ADDR_WIDTH) and
//    off = ea[log2(XLEN/8)-1:0]. If ea[size-1:0] != 0, or size==11 with XLEN==32, latch resp_error=1 and go to
//    RESPOND. Memory signals are not asserted in that case. Otherwise go to ACCESS.
//  - ACCESS: outputs are registered and held stable until mem_ready:
//    - mem_chip_enable = 1; mem_write_enable = req_is_store.
//    - mem_address = ea with its low off bits cleared.
//    - mem_byte_enable = ((1 << 2^size) - 1) << off.
//    - mem_data_store = req_store_data << (8*off).
//    On the cycle mem_ready is 1, capture mem_data_load, drop chip_enable and write_enable on the next edge, and go
//    to RESPOND. mem_ready is ignored outside ACCESS.
//  - Load extraction: raw = mem_data_load >> (8*off), truncated to 2^size bytes. The result is zero-extended if
//    funct3[2] else sign-extended. funct3[2]=1 with size==11 (and with size==10 when XLEN==32) is illegal and sets
//    resp_error. For stores, funct3[2] must be 0, otherwise resp_error.
//  - RESPOND: resp_valid = 1, and resp_* stay stable until resp_ready. On resp_valid && resp_ready go to IDLE.
//    req_ready rises the following cycle; there are no back-to-back accepts.
//  - Minimum latency: accept at edge N, mem_ready high in the first ACCESS cycle, resp_valid high after edge N+2.
//  - Reset in ACCESS or RESPOND aborts immediately: chip_enable drops at that edge, the response is discarded,
//    and the state is IDLE.
// TESTING
//  - LB, base 0x1000, offset 3, memory lane 3 = 0x80 -> byte_enable 0000_1000, resp_data 0xFFFF_FFFF_FFFF_FF80.
//  - LBU, same access -> resp_data 0x0000_0000_0000_0080; LHU at offset 6, lanes = 0xBEEF -> 0xBEEF.
//  - SH, ea 0x2006, data 0x1234 -> mem_address 0x2000, byte_enable 1100_0000, mem_data_store[63:48] = 0x1234,
//    write_enable 1.
//  - LW at ea 0x1002 -> resp_error 1 and resp_data 0 two edges after accept; chip_enable never asserted.
//  - mem_ready delayed 3 cycles and resp_ready delayed 2 -> mem outputs stable throughout, single response,
//    req_ready low until resp is accepted.
//  - reset asserted in the second ACCESS cycle -> next cycle: chip_enable 0, resp_valid 0, req_ready 1;
//    a following LD returns correct data.

Source files
------------

// File: rtl/therm_n1_load_store_unit.sv
// ThermN1 load/store unit: one aligned, byte-enabled memory access per request,
// with load lane extraction and sign/zero extension. Misaligned or illegal ops never touch memory.
module therm_n1_load_store_unit #(
    parameter int XLEN           = 64,
    parameter int ADDR_WIDTH     = 64,
    parameter int RD_WIDTH       = 5,
    parameter int ALLOW_MISALIGN = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_is_store,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_base,
    input  logic [ADDR_WIDTH-1:0] req_offset,
    input  logic [XLEN-1:0]       req_store_data,
    input  logic [RD_WIDTH-1:0]   req_rd,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_chip_enable,
    output logic                  mem_write_enable,
    output logic [XLEN/8-1:0]     mem_byte_enable,
    output logic [XLEN-1:0]       mem_data_store,
    input  logic [XLEN-1:0]       mem_data_load,
    input  logic                  mem_ready,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [RD_WIDTH-1:0]   resp_rd,
    output logic [XLEN-1:0]       resp_data,
    output logic                  resp_error
);
    localparam int BW   = XLEN / 8;
    localparam int OFFW = $clog2(BW);

    typedef enum logic [1:0] {IDLE, ACCESS, RESPOND} state_t;

    typedef struct packed {
        logic                is_store;
        logic                zext;
        logic [1:0]          size;
        logic [OFFW-1:0]     off;
        logic [RD_WIDTH-1:0] rd;
    } op_t;

    state_t          state, state_next;
    op_t             op_q;
    logic [XLEN-1:0] raw_q;

    logic                  accept;
    logic [ADDR_WIDTH-1:0] ea;
    logic [1:0]            size;
    logic [OFFW-1:0]       off;
    logic                  misalign;
    logic                  illegal;
    logic                  reject;
    logic [BW:0]           lane_span;

    function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] raw,
                                               input logic [1:0] sz, input logic zx);
        case (sz)
            2'b00:   return zx ? XLEN'(raw[7:0])  : XLEN'($signed(raw[7:0]));
            2'b01:   return zx ? XLEN'(raw[15:0]) : XLEN'($signed(raw[15:0]));
            2'b10:   return zx ? XLEN'(raw[31:0]) : XLEN'($signed(raw[31:0]));
            default: return raw;
        endcase
    endfunction

    always_comb begin
        accept = req_valid && req_ready;
        ea     = req_base + req_offset;
        size   = req_funct3[1:0];
        off    = ea[OFFW-1:0];
        case (size)
            2'b00:   misalign = 1'b0;
            2'b01:   misalign = ea[0];
            2'b10:   misalign = |ea[1:0];
            default: misalign = |ea[2:0];
        endcase
        // Zero-extension is meaningless for full-width loads and for any store.
        illegal = (size == 2'b11 && XLEN == 32) ||
                  (req_funct3[2] && (req_is_store || size == 2'b11 ||
                                     (size == 2'b10 && XLEN == 32)));
        reject    = misalign || illegal;
        lane_span = ((BW+1)'(1) << (4'd1 << size)) - (BW+1)'(1);
    end

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        req_ready  = (state == IDLE) && !reset;
        case (state)
            IDLE:    if (accept) state_next = reject ? RESPOND : ACCESS;
            ACCESS:  if (mem_ready) state_next = RESPOND;
            RESPOND: if (resp_valid && resp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            op_q             <= '0;
            raw_q            <= '0;
            mem_address      <= '0;
            mem_chip_enable  <= 1'b0;
            mem_write_enable <= 1'b0;
            mem_byte_enable  <= '0;
            mem_data_store   <= '0;
            resp_valid       <= 1'b0;
            resp_rd          <= '0;
            resp_data        <= '0;
            resp_error       <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    op_q       <= '{is_store: req_is_store, zext: req_funct3[2],
                                    size: size, off: off, rd: req_rd};
                    raw_q      <= '0;
                    resp_error <= reject;
                    if (!reject) begin
                        mem_chip_enable  <= 1'b1;
                        mem_write_enable <= req_is_store;
                        mem_address      <= {ea[ADDR_WIDTH-1:OFFW], {OFFW{1'b0}}};
                        mem_byte_enable  <= lane_span[BW-1:0] << off;
                        mem_data_store   <= req_store_data << {off, 3'b000};
                    end
                end
                ACCESS: if (mem_ready) begin
                    raw_q            <= mem_data_load >> {op_q.off, 3'b000};
                    mem_chip_enable  <= 1'b0;
                    mem_write_enable <= 1'b0;
                    mem_byte_enable  <= '0;
                end
                RESPOND: begin
                    // First RESPOND cycle forms the result; it is then held until accepted.
                    if (!resp_valid) begin
                        resp_valid <= 1'b1;
                        resp_rd    <= op_q.is_store ? '0 : op_q.rd;
                        resp_data  <= (resp_error || op_q.is_store) ? '0
                                      : extend(raw_q, op_q.size, op_q.zext);
                    end else if (resp_ready) begin
                        resp_valid <= 1'b0;
                        resp_rd    <= '0;
                        resp_data  <= '0;
                        resp_error <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
